// File: rtl/fifo_flags_if.sv
// Push/pop bus of fifo_flags: write side, registered read side and occupancy/error flags.
// The master drives push/pop/data_in; the slave (the FIFO) drives everything else.
interface fifo_flags_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [1:0]            dest;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, data_in,
        input  data_out, valid_out, dest, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, valid_out, dest, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy flags; FIFO_ERR_STICKY_EN makes overflow/underflow sticky.
// Latency: data_out/valid_out one cycle after an accepted pop; flags decode the registered count.
// Backpressure: push while full (no pop) is dropped and flagged; pop while empty is flagged.
module fifo_flags #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 1
) (
    input  logic         clk,
    input  logic         reset,
    fifo_flags_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_TH);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  vld_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ovf_evt;
    logic                  udf_evt;

    // A full FIFO still takes a push when the same cycle frees a slot.
    always_comb begin
        pop_ok  = bus.pop && (count_q != '0);
        push_ok = bus.push && ((count_q != FULL_CNT) || pop_ok);
        ovf_evt = bus.push && !push_ok;
        udf_evt = bus.pop && !pop_ok;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                dout_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            vld_q <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
                default: count_q <= count_q;
            endcase
`ifdef FIFO_ERR_STICKY_EN
            ovf_q <= ovf_q | ovf_evt;
            udf_q <= udf_q | udf_evt;
`else
            ovf_q <= ovf_evt;
            udf_q <= udf_evt;
`endif
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.valid_out    = vld_q;
    assign bus.dest         = dout_q[DATA_WIDTH-1:DATA_WIDTH-2];
    assign bus.count        = count_q;
    assign bus.full         = (count_q == FULL_CNT);
    assign bus.empty        = (count_q == '0);
    assign bus.almost_full  = (count_q >= AF_CNT);
    assign bus.almost_empty = (count_q != '0) && (count_q <= AE_CNT);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_flags;
    localparam int DW = 6;
    localparam int AW = 3;
`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_TH(6), .AE_TH(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: a queue of stored words plus the last popped word.
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_dout;
    logic          m_vld;
    logic          m_ovf;
    logic          m_udf;

    task automatic model_clear();
        q.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Drive one cycle, then leave the bench at posedge+1 with the model advanced.
    task automatic step(input logic p, input logic o, input logic [DW-1:0] d);
        int sz;
        bit pop_ok;
        bit push_ok;
        sz      = q.size();
        pop_ok  = o && (sz > 0);
        push_ok = p && ((sz < 8) || pop_ok);
        bus.push    = p;
        bus.pop     = o;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        m_vld = pop_ok;
        if (pop_ok) m_dout = q.pop_front();
        if (push_ok) q.push_back(d);
        if (STICKY) begin
            m_ovf = m_ovf | (p && !push_ok);
            m_udf = m_udf | (o && !pop_ok);
        end else begin
            m_ovf = p && !push_ok;
            m_udf = o && !pop_ok;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = '0;
        model_clear();
        @(posedge clk);
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        checks++; if (bus.data_out !== 6'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
        checks++;
        if ({bus.full, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got full/af/ae/ovf/udf=%b want 00000",
                     {bus.full, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow});
        end
        reset = 1'b0;
        step(1'b0, 1'b0, '0);
        checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL idle_after_reset: got empty=%b count=%0d want 1/0", bus.empty, bus.count); end
    endtask

    task automatic test_order();
        logic [DW-1:0] words [3];
        logic [1:0]    dests [3];
        words = '{6'h05, 6'h2A, 6'h3F};
        dests = '{2'd0, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, words[i]);
            checks++; if (bus.count !== 4'(i + 1)) begin errors++; $display("FAIL order_count%0d: got %0d want %0d", i, bus.count, i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, '0);
            checks++; if (bus.data_out !== words[i] || bus.valid_out !== 1'b1) begin errors++; $display("FAIL order_pop%0d: got data=%h valid=%b want %h/1", i, bus.data_out, bus.valid_out, words[i]); end
            checks++; if (bus.dest !== dests[i]) begin errors++; $display("FAIL order_dest%0d: got %0d want %0d", i, bus.dest, dests[i]); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL order_empty: got %b want 1", bus.empty); end
        step(1'b0, 1'b0, '0);
        checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h3F) begin errors++; $display("FAIL order_hold: got valid=%b data=%h want 0/3f", bus.valid_out, bus.data_out); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, DW'($urandom_range(0, 63)));
            checks++;
            if (bus.count !== 4'(i) || bus.almost_full !== (i >= 6) || bus.full !== (i == 8) || bus.almost_empty !== (i == 1)) begin
                errors++;
                $display("FAIL fill%0d: got count=%0d af=%b full=%b ae=%b want %0d/%b/%b/%b",
                         i, bus.count, bus.almost_full, bus.full, bus.almost_empty, i, i >= 6, i == 8, i == 1);
            end
        end
        step(1'b1, 1'b0, 6'h2B);
        checks++; if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL overflow: got ovf=%b count=%0d want 1/8", bus.overflow, bus.count); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0);
            checks++; if (bus.overflow !== STICKY) begin errors++; $display("FAIL overflow_after%0d: got %b want %b", i, bus.overflow, STICKY); end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] head;
        head = q[0];
        step(1'b1, 1'b1, 6'h11);
        checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin errors++; $display("FAIL wrap_count: got %0d full=%b want 8/1", bus.count, bus.full); end
        checks++; if (bus.data_out !== head || bus.valid_out !== 1'b1) begin errors++; $display("FAIL wrap_head: got %h valid=%b want %h/1", bus.data_out, bus.valid_out, head); end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, '0);
            checks++; if (bus.data_out !== m_dout || bus.valid_out !== 1'b1) begin errors++; $display("FAIL wrap_pop%0d: got %h want %h", i, bus.data_out, m_dout); end
        end
        step(1'b0, 1'b1, '0);
        checks++; if (bus.data_out !== 6'h11) begin errors++; $display("FAIL wrap_last: got %h want 11", bus.data_out); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, '0);
        checks++; if (bus.underflow !== 1'b1 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL underflow: got udf=%b valid=%b want 1/0", bus.underflow, bus.valid_out); end
        step(1'b1, 1'b1, 6'h15);
        checks++; if (bus.count !== 4'd1 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL push_pop_empty: got count=%0d valid=%b want 1/0", bus.count, bus.valid_out); end
        step(1'b0, 1'b1, '0);
        checks++; if (bus.data_out !== 6'h15 || bus.underflow !== STICKY) begin errors++; $display("FAIL after_push_pop: got data=%h udf=%b want 15/%b", bus.data_out, bus.underflow, STICKY); end
    endtask

    task automatic test_random();
        bit p;
        bit o;
        int sz;
        for (int i = 0; i < 400; i++) begin
            if ((i / 50) % 2 == 0) begin
                p = ($urandom_range(0, 3) != 0);
                o = ($urandom_range(0, 3) == 0);
            end else begin
                p = ($urandom_range(0, 3) == 0);
                o = ($urandom_range(0, 3) != 0);
            end
            step(p, o, DW'($urandom_range(0, 63)));
            sz = q.size();
            checks++;
            if (bus.count !== 4'(sz) || bus.full !== (sz == 8) || bus.empty !== (sz == 0) ||
                bus.almost_full !== (sz >= 6) || bus.almost_empty !== (sz == 1)) begin
                errors++;
                $display("FAIL rand_flags%0d: got count=%0d full=%b empty=%b af=%b ae=%b want count=%0d", i,
                         bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty, sz);
            end
            checks++;
            if (bus.valid_out !== m_vld || bus.data_out !== m_dout || bus.dest !== m_dout[DW-1:DW-2] ||
                bus.overflow !== m_ovf || bus.underflow !== m_udf) begin
                errors++;
                $display("FAIL rand_out%0d: got v=%b d=%h ovf=%b udf=%b want v=%b d=%h ovf=%b udf=%b", i,
                         bus.valid_out, bus.data_out, bus.overflow, bus.underflow, m_vld, m_dout, m_ovf, m_udf);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(i + 1));
        step(1'b1, 1'b1, 6'h0A);
        bus.push = 1'b1;
        bus.data_in = 6'h0B;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL async_count: got %0d empty=%b want 0/1", bus.count, bus.empty); end
        checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h00) begin errors++; $display("FAIL async_out: got valid=%b data=%h want 0/00", bus.valid_out, bus.data_out); end
        bus.push = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        step(1'b0, 1'b1, '0);
        checks++; if (bus.valid_out !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL async_discard: got valid=%b count=%0d want 0/0", bus.valid_out, bus.count); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_fill();
        test_wrap();
        test_underflow();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Synchronous FIFO with occupancy flags, instantiated 4x upstream and 4x downstream of the weighted round-robin arbiter in the pcie_v2 datapath.
- Accepts words on push and returns them on pop, with one cycle of read latency.
- Produces the full, empty, almost_full and almost_empty flags that the arbiter uses for its pop and push decisions.
- Exposes the 2-bit destination field of the word being read so the arbiter can steer pushes.

Parameters:
- DATA_WIDTH, 6, word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination field.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8.
- AF_TH, 6, almost_full asserts when count >= AF_TH.
- AE_TH, 1, almost_empty asserts when 0 < count <= AE_TH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write data_in this cycle.
- pop  input  1  read head word this cycle.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped in the previous cycle.
- dest  output  2  data_out[DATA_WIDTH-1:DATA_WIDTH-2].
- full  output  1  count == 2**ADDR_WIDTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_TH.
- almost_empty  output  1  0 < count <= AE_TH.
- count  output  ADDR_WIDTH+1  current occupancy.
- overflow  output  1  push was rejected (FIFO full).
- underflow  output  1  pop was rejected (FIFO empty).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, overflow=0, underflow=0.
  - Flags after reset: empty=1, full=0, almost_full=0, almost_empty=0.
  - Memory contents are not reset.
- Reset mid-operation: all state clears immediately, regardless of the clock. Stored words are discarded.
- Flags are combinational decodes of the registered count. They are therefore valid in the cycle after the push or pop that changed count.
- Pointers are ADDR_WIDTH bits wide and wrap naturally from 7 to 0. count is tracked separately, so full and empty are never ambiguous.
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted pop:
  - data_out <= mem[rd_ptr]; rd_ptr increments; valid_out <= 1 in the next cycle.
  - Read latency is 1 cycle, matching the arbiter's valid-one-cycle-after-pop timing.
- No accepted pop: valid_out <= 0; data_out holds its last value.
- Acceptance rules:
  - Push is accepted when !full, or when full and pop is accepted in the same cycle.
  - Pop is accepted when !empty.
- Simultaneous push and pop:
  - Not empty: both are accepted, count is unchanged, and the read returns the old head.
  - Empty: the push is accepted, the pop is rejected, and count becomes 1. There is no fall-through of the pushed word.
  - Full: both are accepted and count stays 8.
- count update: +1 on accepted push only, -1 on accepted pop only, unchanged otherwise.
- Rejected push (full and no pop): data is dropped, pointers are unchanged, overflow is raised.
- Rejected pop (empty): pointers are unchanged, valid_out=0, underflow is raised.
- No state machine beyond the pointers and count. All storage updates on the rising edge of clk.

Optional Feature:
- Macro: FIFO_ERR_STICKY_EN.
- Defined: overflow and underflow are sticky. They stay at 1 after the first error until reset.
- Undefined: overflow and underflow are single-cycle pulses, registered, asserted in the cycle after the offending push or pop.

Test Plan:
- Reset then idle -> empty=1, count=0, valid_out=0, all other flags 0. Assert reset asynchronously mid-burst -> outputs clear before the next clk edge.
- Push 0x05, 0x2A, 0x3F; then pop 3 times -> data_out shows 0x05, 0x2A, 0x3F on consecutive cycles, each valid_out=1 one cycle after its pop; dest = 0, 2, 3; empty=1 at the end.
- Fill with 8 pushes -> almost_full=1 once count=6, full=1 at count=8. A 9th push without pop -> word dropped, overflow=1, count=8.
- Full FIFO with push 0x11 and pop in the same cycle -> count stays 8 and the head word is returned. After 7 more pops, the 8th pop returns 0x11 (pointer wrap-around verified).
- Empty FIFO with pop only -> underflow=1, valid_out=0. Empty FIFO with push and pop together -> count=1, valid_out=0 next cycle.
- Error flag behaviour:
  - FIFO_ERR_STICKY_EN defined: an overflow followed by 5 normal cycles leaves overflow=1.
  - Undefined: overflow is high for exactly 1 cycle.
